target_controller: RTL
======================

TARGET_CONTROLLER -- requirements
Module: target_controller

Interface
REQ-001 Parameter SPRITE_W, default 630: drawn sprite width in pixels (two mirrored tiles).
REQ-002 Parameter SPRITE_H, default 262: drawn sprite height in pixels.
REQ-003 Parameter SCREEN_W, default 1024; SCREEN_H, default 768: visible raster size.
REQ-004 Parameter STEP_X, default 4; STEP_Y, default 2: pixels moved per frame on each axis.
REQ-005 Parameter FLASH_FRAMES, default 30: length of the hit-flash period, in frames.
REQ-006 clk  input  1  system pixel clock; the only clock.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 vsync  input  1  active-low raster vertical sync.
REQ-009 enable  input  1  level; high runs the game, low forces IDLE.
REQ-010 start  input  1  one-clock pulse; launches the target from IDLE.
REQ-011 hit  input  1  one-clock pulse; the target was struck.
REQ-012 x  output  11  sprite left edge, registered.
REQ-013 y  output  10  sprite top edge, registered.
REQ-014 visible  output  1  high when the sprite is drawn, registered.
REQ-015 state  output  2  IDLE=0, ACTIVE=1, FLASH=2, RESPAWN=3.
REQ-016 hit_count  output  8  accepted hits, saturating.

Function
REQ-017 frame_tick is a one-clock pulse on the clock after vsync is sampled high, then low (registered falling edge).
REQ-018 Limits: XMAX=SCREEN_W-SPRITE_W (394); YMAX=SCREEN_H-SPRITE_H (506).
REQ-019 lfsr is 20 bits, reset to 20'h1ACE5, taps 20 and 17, advances every clock, and never reaches zero.
REQ-020 IDLE: visible=0; x and y hold; start with enable=1 -> ACTIVE next clock, dx=+STEP_X, dy=+STEP_Y, visible=1.
REQ-021 ACTIVE, on each frame_tick: x=x+dx and y=y+dy, computed in 12-bit signed arithmetic.
REQ-022 Bounce: a result above XMAX clamps to XMAX and negates dx; a result below 0 clamps to 0 and negates dx. y uses YMAX and dy the same way.
REQ-023 ACTIVE, on hit: hit_count increments, saturating at 255; flash_cnt clears; state -> FLASH; x and y freeze.
REQ-024 If hit and frame_tick arrive in the same cycle in ACTIVE, hit wins and the position is not updated that frame.
REQ-025 hit is ignored in IDLE, FLASH and RESPAWN.
REQ-026 FLASH: flash_cnt increments on each frame_tick; visible = ~flash_cnt[2], so the sprite toggles every 4 frames.
REQ-027 FLASH: on the frame_tick where flash_cnt reaches FLASH_FRAMES-1, state -> RESPAWN.
REQ-028 RESPAWN lasts exactly one clock.
REQ-029 On RESPAWN: x=min(lfsr[9:0],XMAX); y=min(lfsr[19:10],YMAX); dx sign=lfsr[0]; dy sign=lfsr[1]; visible=1; state -> ACTIVE.
REQ-030 Sign convention: a sign bit of 1 means negative.
REQ-031 enable=0 in any state -> IDLE next clock; visible=0; hit_count and position are retained.
REQ-032 When enable=0 and start arrive in the same cycle, enable=0 wins.

Reset
REQ-033 Reset applies on a clock edge with reset_n=0 and overrides all other inputs.
REQ-034 Reset values: state=IDLE, x=0, y=0, visible=0, hit_count=0, flash_cnt=0, dx=+STEP_X, dy=+STEP_Y, vsync history=1.
REQ-035 Reset asserted mid-FLASH or mid-RESPAWN returns the block to IDLE with no partial update.

Verification
REQ-036 Reset; pulse start; send 3 frame_ticks -> state=1, x=12, y=6, visible=1.
REQ-037 ACTIVE at x=392 with dx=+4; send frame_tick -> x=394, dx=-4; next frame_tick -> x=390.
REQ-038 Pulse hit on the same cycle as frame_tick at x=100 -> state=2, x=100, hit_count=1.
REQ-039 FLASH: send 30 frame_ticks -> visible toggles every 4 frames; one clock of state=3; then state=1 with x<=394, y<=506, visible=1.
REQ-040 Apply 256 accepted hits -> hit_count=255, no wrap.
REQ-041 Drop enable mid-ACTIVE -> IDLE next clock, visible=0; a later start resumes from the retained x and y.

Source files
------------

// File: rtl/target_controller.sv
// rtl/target_controller.sv - bouncing target sprite: frame-tick movement, hit flash, LFSR respawn
module target_controller #(
  parameter int SPRITE_W     = 630,
  parameter int SPRITE_H     = 262,
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 2,
  parameter int FLASH_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        enable,
  input  logic        start,
  input  logic        hit,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        visible,
  output logic [1:0]  state,
  output logic [7:0]  hit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    FLASH   = 2'd2,
    RESPAWN = 2'd3
  } state_e;

  localparam logic signed [11:0] XMAX_S     = 12'(SCREEN_W - SPRITE_W);
  localparam logic signed [11:0] YMAX_S     = 12'(SCREEN_H - SPRITE_H);
  localparam logic [10:0]        XMAX_X     = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]         YMAX_Y     = 10'(SCREEN_H - SPRITE_H);
  localparam logic signed [11:0] STEP_XS    = 12'(STEP_X);
  localparam logic signed [11:0] STEP_YS    = 12'(STEP_Y);
  localparam logic [7:0]         FLASH_LAST = 8'(FLASH_FRAMES - 1);

  state_e      state_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        visible_q;
  logic [7:0]  hit_count_q;
  logic [7:0]  flash_cnt_q;
  logic        dx_neg_q;
  logic        dy_neg_q;
  logic        vsync_q;
  logic        frame_tick_q;
  logic [19:0] lfsr_q;

  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;
  logic [10:0]        x_d;
  logic [9:0]         y_d;
  logic               dx_neg_d;
  logic               dy_neg_d;
  logic [10:0]        spawn_x;
  logic [9:0]         spawn_y;
  logic [7:0]         flash_cnt_d;

  // Signed sum so a step past the left/top edge shows up as negative and can be clamped.
  always_comb begin
    x_sum    = $signed({1'b0, x_q}) + (dx_neg_q ? -STEP_XS : STEP_XS);
    x_d      = x_sum[10:0];
    dx_neg_d = dx_neg_q;
    if (x_sum > XMAX_S) begin
      x_d      = XMAX_X;
      dx_neg_d = ~dx_neg_q;
    end else if (x_sum < 12'sd0) begin
      x_d      = '0;
      dx_neg_d = ~dx_neg_q;
    end

    y_sum    = $signed({2'b00, y_q}) + (dy_neg_q ? -STEP_YS : STEP_YS);
    y_d      = y_sum[9:0];
    dy_neg_d = dy_neg_q;
    if (y_sum > YMAX_S) begin
      y_d      = YMAX_Y;
      dy_neg_d = ~dy_neg_q;
    end else if (y_sum < 12'sd0) begin
      y_d      = '0;
      dy_neg_d = ~dy_neg_q;
    end

    spawn_x     = ({1'b0, lfsr_q[9:0]} > XMAX_X) ? XMAX_X : {1'b0, lfsr_q[9:0]};
    spawn_y     = (lfsr_q[19:10] > YMAX_Y) ? YMAX_Y : lfsr_q[19:10];
    flash_cnt_d = flash_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      visible_q    <= 1'b0;
      hit_count_q  <= '0;
      flash_cnt_q  <= '0;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      lfsr_q       <= 20'h1ACE5;
    end else begin
      lfsr_q       <= {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
      vsync_q      <= vsync;
      frame_tick_q <= vsync_q & ~vsync;

      if (!enable) begin
        state_q   <= IDLE;
        visible_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q   <= ACTIVE;
              dx_neg_q  <= 1'b0;
              dy_neg_q  <= 1'b0;
              visible_q <= 1'b1;
            end
          end
          ACTIVE: begin
            // A hit in the same cycle as a frame tick freezes the sprite where it is.
            if (hit) begin
              if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
              flash_cnt_q <= '0;
              visible_q   <= 1'b1;
              state_q     <= FLASH;
            end else if (frame_tick_q) begin
              x_q      <= x_d;
              y_q      <= y_d;
              dx_neg_q <= dx_neg_d;
              dy_neg_q <= dy_neg_d;
            end
          end
          FLASH: begin
            if (frame_tick_q) begin
              flash_cnt_q <= flash_cnt_d;
              visible_q   <= ~flash_cnt_d[2];
              if (flash_cnt_d == FLASH_LAST) state_q <= RESPAWN;
            end
          end
          RESPAWN: begin
            x_q       <= spawn_x;
            y_q       <= spawn_y;
            dx_neg_q  <= lfsr_q[0];
            dy_neg_q  <= lfsr_q[1];
            visible_q <= 1'b1;
            state_q   <= ACTIVE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign visible   = visible_q;
  assign state     = state_q;
  assign hit_count = hit_count_q;

endmodule
